// File: rtl/wram_stream_reader_if.sv
// wram_stream_reader_if: command, RAM read-port and output-stream bundle for wram_stream_reader.
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : command handshake (start address, word count)
//   ReadAddress1/2, ReadBus1/2           : the two combinational weight-RAM read ports
//   out_valid/out_ready/out_data/out_last: output word stream to the compute datapath
//   busy/done/cmd_err                    : engine status
// master modport is the reader engine, slave modport is the environment around it.
interface wram_stream_reader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 14
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] ReadAddress1;
    logic [ADDR_W-1:0] ReadAddress2;
    logic [DATA_W-1:0] ReadBus1;
    logic [DATA_W-1:0] ReadBus2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              cmd_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ReadBus1, ReadBus2, out_ready,
        output cmd_ready, ReadAddress1, ReadAddress2, out_valid, out_data, out_last,
               busy, done, cmd_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ReadBus1, ReadBus2, out_ready,
        input  cmd_ready, ReadAddress1, ReadAddress2, out_valid, out_data, out_last,
               busy, done, cmd_err
    );
endinterface

// File: rtl/wram_stream_reader.sv
// wram_stream_reader: streams a (start address, word count) range of the weight RAM out over valid/ready.
//   clock   : sole clock, rising edge
//   reset_n : synchronous reset, active-low
//   io_bus  : wram_stream_reader_if.master (command in, RAM read ports, output stream, status)
// Fetches an even/odd address pair per cycle into a small FIFO and marks the final word.
// Optional macro WRAM_RD_BOUNDS_EN: reject commands running past the end of the RAM (cmd_err pulse).
module wram_stream_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 128,
    parameter int LEN_W      = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    wram_stream_reader_if.master io_bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [LEN_W-1:0]  r_rem;
    logic [1:0]        r_fl_n;
    logic              r_fl_last;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_last;
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [PTR_W:0]    r_cnt;
    logic              r_done;
    logic              r_err;
    logic              w_accept;
    logic              w_reject;
    logic              w_zero;
    logic              w_fetch;
    logic              w_rem_end;
    logic              w_pop;
    logic              w_empty;
    logic [1:0]        w_fetch_n;

    assign w_accept  = io_bus.cmd_valid && (r_state == IDLE);
`ifdef WRAM_RD_BOUNDS_EN
    localparam int RAM_DEPTH = 2 ** ADDR_W;
    assign w_reject  = int'(io_bus.cmd_len) > RAM_DEPTH - int'(io_bus.cmd_addr);
`else
    assign w_reject  = 1'b0;
`endif
    assign w_zero    = w_accept && !w_reject && (io_bus.cmd_len == '0);
    assign w_empty   = (r_cnt == '0);
    assign w_pop     = !w_empty && io_bus.out_ready;
    assign w_fetch_n = (r_rem >= LEN_W'(2)) ? 2'd2 : 2'd1;
    assign w_rem_end = (r_rem == LEN_W'(w_fetch_n));
    // Reserve room for the words already in flight so a fetch can never overflow the FIFO.
    assign w_fetch   = (r_state == FETCH) &&
                       (int'(r_cnt) + int'(r_fl_n) + int'(w_fetch_n) <= FIFO_DEPTH);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) begin
            w_next = (w_accept && !w_reject && (io_bus.cmd_len != '0)) ? FETCH : IDLE;
        end else if (r_state == FETCH) begin
            w_next = (w_fetch && w_rem_end) ? DRAIN : FETCH;
        end else begin
            w_next = (w_empty && (r_fl_n == 2'd0)) ? IDLE : DRAIN;
        end
    end

    always_comb begin
        io_bus.cmd_ready    = (r_state == IDLE);
        io_bus.busy         = (r_state != IDLE);
        io_bus.ReadAddress1 = r_addr1;
        io_bus.ReadAddress2 = r_addr2;
        io_bus.out_valid    = !w_empty;
        io_bus.out_data     = w_empty ? '0 : r_mem[r_rp];
        io_bus.out_last     = !w_empty && r_last[r_rp];
        io_bus.done         = r_done;
        io_bus.cmd_err      = r_err;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            r_rem     <= '0;
            r_addr1   <= '0;
            r_addr2   <= '0;
            r_fl_n    <= 2'd0;
            r_fl_last <= 1'b0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done    <= w_zero || ((r_state == DRAIN) && (w_next == IDLE));
            r_err     <= w_accept && w_reject;
            if (w_accept) begin
                r_ptr <= io_bus.cmd_addr;
                r_rem <= io_bus.cmd_len;
            end else if (w_fetch) begin
                r_ptr   <= r_ptr + ADDR_W'(2);
                r_rem   <= r_rem - LEN_W'(w_fetch_n);
                r_addr1 <= r_ptr;
                // A single trailing word reads the same address on both ports; port 2 is ignored.
                r_addr2 <= (w_fetch_n == 2'd2) ? r_ptr + ADDR_W'(1) : r_ptr;
            end
            r_fl_n    <= w_fetch ? w_fetch_n : 2'd0;
            r_fl_last <= w_fetch && w_rem_end;
            r_wp      <= r_wp + PTR_W'(r_fl_n);
            r_rp      <= r_rp + PTR_W'(w_pop);
            r_cnt     <= r_cnt + (PTR_W+1)'(r_fl_n) - (PTR_W+1)'(w_pop);
        end
    end

    // Words land one edge after their address; the final word of a fetch carries the last flag.
    always_ff @(posedge clock) begin
        if (r_fl_n != 2'd0) begin
            r_mem[r_wp]  <= io_bus.ReadBus1;
            r_last[r_wp] <= r_fl_last && (r_fl_n == 2'd1);
        end
        if (r_fl_n == 2'd2) begin
            r_mem[r_wp + PTR_W'(1)]  <= io_bus.ReadBus2;
            r_last[r_wp + PTR_W'(1)] <= r_fl_last;
        end
    end
endmodule

// File: doc/wram_stream_reader.md
Name: wram_stream_reader

Overview:
- Read-side engine for the 8192 x 128-bit weight RAM.
- Accepts a (start address, word count) command and drives both combinational RAM read ports with an even/odd address pair.
- Captures the returned words into a 4-entry output FIFO and streams them to the compute datapath over a valid/ready interface, marking the final word.
- Sits between the weight RAM and the consumer; it issues no writes.

Parameters:
- ADDR_W, 13, RAM address width; depth = 2**ADDR_W.
- DATA_W, 128, RAM word width.
- LEN_W, 14, command length width; holds 0..2**ADDR_W.
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ 2 and a power of 2.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command; equals (state == IDLE).
- cmd_addr  in  ADDR_W  first word address.
- cmd_len  in  LEN_W  number of words to stream.
- ReadAddress1  out  ADDR_W  to RAM read port 1 (even slot of pair).
- ReadAddress2  out  ADDR_W  to RAM read port 2 (odd slot of pair).
- ReadBus1  in  DATA_W  RAM data for ReadAddress1.
- ReadBus2  in  DATA_W  RAM data for ReadAddress2.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts word.
- out_data  out  DATA_W  streamed word (FIFO head).
- out_last  out  1  out_data is the final word of the command.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle pulse when a command fully completes.
- cmd_err  out  1  one-cycle pulse on rejected command (optional feature only).

Behaviour:
- Reset: reset_n low at a rising edge sets the following, regardless of in-flight activity:
  - state = IDLE; FIFO flushed.
  - ReadAddress1/2 = 0; out_data = 0.
  - out_valid, out_last, busy, done, cmd_err = 0; cmd_ready = 1.
- Reset mid-command discards every pending word; no done pulse.
- States:
  - IDLE: on cmd_valid & cmd_ready, latch ptr = cmd_addr and rem = cmd_len.
    - cmd_len == 0: stay IDLE and pulse done the next cycle; nothing is streamed.
    - Otherwise go to FETCH.
  - FETCH: each cycle, issue one fetch if (FIFO occupancy + in-flight words + words-this-fetch) ≤ FIFO_DEPTH.
    - Fetch with rem ≥ 2: ReadAddress1 = ptr, ReadAddress2 = ptr+1; rem -= 2; ptr += 2.
    - Fetch with rem == 1: ReadAddress1 = ptr, ReadAddress2 = ptr; only the port-1 word is used; rem = 0.
    - Go to DRAIN when rem reaches 0.
  - DRAIN: when the FIFO is empty and nothing is in flight, pulse done and go to IDLE.
- Read timing:
  - Read addresses are registered, updated at edge N.
  - RAM data is sampled at edge N+1 and pushed into the FIFO in the same edge; ReadBus1 is written first, then ReadBus2.
- Latency: for a command accepted at edge E with out_ready held high:
  - addresses are valid after E+1;
  - out_valid rises after E+2;
  - sustained rate is 1 word/cycle.
- Handshake rules:
  - A word transfers on out_valid & out_ready.
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- out_last is high on exactly one word per command with cmd_len ≥ 1: word number cmd_len-1.
- Address arithmetic: modulo 2**ADDR_W.
  - ptr+1 and ptr+2 wrap; e.g. ptr = 8191 issues the pair (8191, 0).
- Simultaneous FIFO push and pop in one cycle is legal; occupancy changes by push count minus pop count.
- A new command is accepted only in IDLE. The cycle done pulses is IDLE, so back-to-back commands accept there.

Optional Feature:
- Macro: WRAM_RD_BOUNDS_EN.
- Defined: a command with cmd_len > 2**ADDR_W - cmd_addr is rejected.
  - It is accepted, nothing is streamed and no RAM address changes.
  - cmd_err pulses the next cycle and done does not pulse; state stays IDLE.
- Undefined: cmd_err is tied 0 and addresses wrap as described above.

Test Plan:
- RAM[i] = i; command addr=10, len=5, out_ready=1 → out_data 10,11,12,13,14 on consecutive cycles; out_last on 14; done one cycle after the last transfer.
- Command addr=8190, len=4 (macro off) → words 8190, 8191, 0, 1; ReadAddress pair (8190,8191), then (0,1).
- Command addr=0, len=8 with out_ready toggling 1,0,0,1,… → all 8 words in order, none duplicated or dropped; out_data stable while stalled; FIFO never exceeds 4 entries.
- Command len=0 → done pulses one cycle after acceptance; out_valid stays 0.
- reset_n low for one edge after the 3rd word of a len=16 command → all outputs at reset values; a new command addr=100, len=2 then streams 100, 101 correctly.
- Macro on: command addr=8190, len=4 → cmd_err pulses, no out_valid, no done; command addr=8188, len=4 → normal completion.
